// File: rtl/aurora_hls_crc_monitor_pkg.sv
// Shared link-state encoding and sizing helper for the multi-channel Aurora CRC monitor.
package aurora_hls_crc_pkg;

  typedef enum logic [1:0] {
    LINK_OK       = 2'd0,
    LINK_DEGRADED = 2'd1,
    LINK_FAILED   = 2'd2
  } link_state_e;

  // Run counters only need to hold values up to the larger of the two thresholds.
  function automatic int run_cnt_width(input int err_thresh, input int good_thresh);
    int m;
    m = (err_thresh > good_thresh) ? err_thresh : good_thresh;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aurora_hls_crc_monitor_if.sv
// Bus bundle between the Aurora RX CRC checkers / host and the CRC monitor.
interface aurora_hls_crc_monitor_if #(
  parameter int NUM_CH    = 4,
  parameter int CNT_WIDTH = 32
);
  // All inputs are strobes without backpressure: one frame result per channel per
  // cycle where crc_valid is high, and snap_req is a single-cycle request that is
  // always accepted and answered by exactly one snap_valid pulse on the next cycle.
  logic [NUM_CH-1:0]           crc_valid;
  logic [NUM_CH-1:0]           crc_pass_fail_n;
  logic                        snap_req;
  logic                        snap_clear;
  logic                        snap_valid;
  logic [NUM_CH*CNT_WIDTH-1:0] frames_received;
  logic [NUM_CH*CNT_WIDTH-1:0] frames_with_errors;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_frames_received;
  logic [NUM_CH*CNT_WIDTH-1:0] snap_frames_with_errors;
  logic [2*NUM_CH-1:0]         link_state;
  logic                        link_failed;

  modport master (
    output crc_valid, crc_pass_fail_n, snap_req, snap_clear,
    input  snap_valid, frames_received, frames_with_errors,
           snap_frames_received, snap_frames_with_errors, link_state, link_failed
  );

  modport slave (
    input  crc_valid, crc_pass_fail_n, snap_req, snap_clear,
    output snap_valid, frames_received, frames_with_errors,
           snap_frames_received, snap_frames_with_errors, link_state, link_failed
  );
endinterface

// File: rtl/aurora_hls_crc_monitor_channel.sv
// One CRC channel: frame/error counters with snapshot clear, plus the link-health FSM.
// AURORA_HLS_CRC_SATURATE_EN: counters stick at all-ones instead of wrapping.
module aurora_hls_crc_channel
  import aurora_hls_crc_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int ERR_THRESH  = 4,
  parameter int GOOD_THRESH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 pass,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] frames,
  output logic [CNT_WIDTH-1:0] errors,
  output logic [1:0]           state,
  output logic                 failed_nxt
);

  localparam int RW = run_cnt_width(ERR_THRESH, GOOD_THRESH);
  // Comparing against threshold-1 means "this event makes the run reach the threshold".
  localparam logic [RW-1:0] ERR_LAST  = RW'(ERR_THRESH - 1);
  localparam logic [RW-1:0] GOOD_LAST = RW'(GOOD_THRESH - 1);

  function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
`ifdef AURORA_HLS_CRC_SATURATE_EN
    return (&v) ? v : v + CNT_WIDTH'(1);
`else
    return v + CNT_WIDTH'(1);
`endif
  endfunction

  logic [CNT_WIDTH-1:0] frames_n, errors_n, frames_base, errors_base;
  link_state_e          st, st_n;
  logic [RW-1:0]        err_run, err_run_n, pass_run, pass_run_n;

  // A clear restarts from zero but still counts the event of the same cycle.
  always_comb begin
    frames_base = clear ? '0 : frames;
    errors_base = clear ? '0 : errors;
    frames_n    = frames_base;
    errors_n    = errors_base;
    if (valid) begin
      frames_n = bump(frames_base);
      if (!pass) errors_n = bump(errors_base);
    end
  end

  always_comb begin
    st_n       = st;
    err_run_n  = err_run;
    pass_run_n = pass_run;
    if (valid) begin
      case (st)
        LINK_OK: begin
          if (!pass) begin
            if (ERR_THRESH == 1) st_n = LINK_FAILED;
            else begin
              st_n      = LINK_DEGRADED;
              err_run_n = RW'(1);
            end
          end
        end
        LINK_DEGRADED: begin
          if (!pass) begin
            pass_run_n = '0;
            if (err_run == ERR_LAST) begin
              st_n      = LINK_FAILED;
              err_run_n = '0;
            end else err_run_n = err_run + RW'(1);
          end else begin
            err_run_n = '0;
            if (pass_run == GOOD_LAST) begin
              st_n       = LINK_OK;
              pass_run_n = '0;
            end else pass_run_n = pass_run + RW'(1);
          end
        end
        LINK_FAILED: begin
          if (!pass) pass_run_n = '0;
          else if (pass_run == GOOD_LAST) begin
            st_n       = LINK_OK;
            pass_run_n = '0;
          end else pass_run_n = pass_run + RW'(1);
        end
        default: begin
          st_n       = LINK_OK;
          err_run_n  = '0;
          pass_run_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frames   <= '0;
      errors   <= '0;
      st       <= LINK_OK;
      err_run  <= '0;
      pass_run <= '0;
    end else begin
      frames   <= frames_n;
      errors   <= errors_n;
      st       <= st_n;
      err_run  <= err_run_n;
      pass_run <= pass_run_n;
    end
  end

  assign state      = st;
  assign failed_nxt = (st_n == LINK_FAILED);

endmodule

// File: rtl/aurora_hls_crc_monitor.sv
// Multi-channel Aurora CRC monitor: per-channel counters/health plus atomic snapshot.
// AURORA_HLS_CRC_SATURATE_EN selects saturating counters inside each channel.
module aurora_hls_crc_monitor
  import aurora_hls_crc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_WIDTH   = 32,
  parameter int ERR_THRESH  = 4,
  parameter int GOOD_THRESH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  aurora_hls_crc_monitor_if.slave  bus
);

  logic [NUM_CH*CNT_WIDTH-1:0] fr_live, er_live, fr_snap, er_snap;
  logic [2*NUM_CH-1:0]         st_live;
  logic [NUM_CH-1:0]           fail_nxt;
  logic                        clear, snap_valid_q, link_failed_q;

  assign clear = bus.snap_req & bus.snap_clear;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aurora_hls_crc_channel #(
      .CNT_WIDTH  (CNT_WIDTH),
      .ERR_THRESH (ERR_THRESH),
      .GOOD_THRESH(GOOD_THRESH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .valid     (bus.crc_valid[i]),
      .pass      (bus.crc_pass_fail_n[i]),
      .clear     (clear),
      .frames    (fr_live[i*CNT_WIDTH +: CNT_WIDTH]),
      .errors    (er_live[i*CNT_WIDTH +: CNT_WIDTH]),
      .state     (st_live[2*i +: 2]),
      .failed_nxt(fail_nxt[i])
    );
  end

  // Snapshot takes the pre-edge live values, so same-cycle events land only in the live set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fr_snap       <= '0;
      er_snap       <= '0;
      snap_valid_q  <= 1'b0;
      link_failed_q <= 1'b0;
    end else begin
      snap_valid_q  <= bus.snap_req;
      link_failed_q <= |fail_nxt;
      if (bus.snap_req) begin
        fr_snap <= fr_live;
        er_snap <= er_live;
      end
    end
  end

  assign bus.frames_received         = fr_live;
  assign bus.frames_with_errors      = er_live;
  assign bus.snap_frames_received    = fr_snap;
  assign bus.snap_frames_with_errors = er_snap;
  assign bus.link_state              = st_live;
  assign bus.snap_valid              = snap_valid_q;
  assign bus.link_failed             = link_failed_q;

endmodule
